// File: rtl/fetch_pc_redirect_pkg.sv
// Shared types and constants for the IF-stage PC generator.
// It provides the PC width, the instruction size, the flush-counter type and the RUN/FLUSH encoding.
package fetch_pc_redirect_pkg;

  localparam int unsigned PcW        = 32;
  localparam int unsigned InstrBytes = 4;
  localparam int unsigned FlushCntW  = 3;

  localparam logic [PcW-1:0] DefaultResetPc = 32'h0000_0000;

  typedef enum logic {
    StRun   = 1'b0,
    StFlush = 1'b1
  } fetch_state_e;

  typedef logic [FlushCntW-1:0] flush_cnt_t;

  // Fetch addresses are always word aligned; the low bits of a target are dropped.
  function automatic logic [PcW-1:0] word_align(input logic [PcW-1:0] addr);
    return {addr[PcW-1:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [PcW-1:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/fetch_pc_redirect_flush_timer.sv
// Loadable flush down-counter with stall hold. It drives the registered IF/ID and ID/EX squash
// controls.
module fetch_pc_redirect_flush_timer
  import fetch_pc_redirect_pkg::*;
#(
  parameter int unsigned BrFlush = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic       load_br_i,
  input  flush_cnt_t load_val_i,
  input  logic       stall_i,
  output logic       active_o,
  output logic       flush_ifid_o,
  output logic       flush_idex_o
);

  localparam flush_cnt_t BrCnt = flush_cnt_t'(BrFlush);

  fetch_state_e state_q, state_d;
  flush_cnt_t   cnt_q, cnt_d;
  logic         from_br_q, from_br_d;
  logic         ifid_q, ifid_d;
  logic         idex_q, idex_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    from_br_d = from_br_q;
    unique case (state_q)
      StRun: begin
        if (load_i) begin
          cnt_d     = load_val_i;
          from_br_d = load_br_i;
          if (load_val_i != '0) begin
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        if (!stall_i) begin
          cnt_d = cnt_q - flush_cnt_t'(1);
          if (cnt_q == flush_cnt_t'(1)) begin
            state_d = StRun;
          end
        end
      end
    endcase
    // ID/EX is squashed only in the first slot after a taken branch. A stall keeps that slot alive.
    ifid_d = (cnt_d != '0);
    idex_d = from_br_d && (cnt_d != '0) && (cnt_d == BrCnt);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StRun;
      cnt_q     <= '0;
      from_br_q <= 1'b0;
      ifid_q    <= 1'b0;
      idex_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      from_br_q <= from_br_d;
      ifid_q    <= ifid_d;
      idex_q    <= idex_d;
    end
  end

  assign active_o     = (state_q == StFlush);
  assign flush_ifid_o = ifid_q;
  assign flush_idex_o = idex_q;

endmodule

// File: rtl/fetch_pc_redirect.sv
// IF-stage fetch PC generator. It accepts branch and jump redirects and issues a timed squash of
// wrong-path slots.
module fetch_pc_redirect
  import fetch_pc_redirect_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DefaultResetPc,
  parameter int unsigned BR_FLUSH  = 2,
  parameter int unsigned JMP_FLUSH = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic             jmp_valid,
  input  logic [31:0]      jmp_target,
  output logic [31:0]      pc_out,
  output logic [31:0]      pc_plus4,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             redirect,
  output logic             misalign,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam flush_cnt_t BrCnt  = flush_cnt_t'(BR_FLUSH);
  localparam flush_cnt_t JmpCnt = flush_cnt_t'(JMP_FLUSH);

  logic [PcW-1:0]   pc_q, pc_d;
  logic             redirect_q, redirect_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             flush_active;
  logic             take_redirect;
  logic [PcW-1:0]   target;
  flush_cnt_t       load_val;

  // Redirect sources are wrong-path while a flush is running, so they are only heard in RUN.
  assign take_redirect = !flush_active && (br_taken || jmp_valid);
  assign target        = br_taken ? br_target : jmp_target;
  assign load_val      = br_taken ? BrCnt : JmpCnt;

  always_comb begin
    pc_d       = pc_q;
    redirect_d = 1'b0;
    misalign_d = misalign_q;
    cnt_d      = cnt_q;
    if (take_redirect) begin
      pc_d       = word_align(target);
      redirect_d = 1'b1;
      if (is_misaligned(target)) begin
        misalign_d = 1'b1;
      end
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (!stall) begin
      pc_d = pc_q + PcW'(InstrBytes);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  fetch_pc_redirect_flush_timer #(
    .BrFlush (BR_FLUSH)
  ) u_flush_timer (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .load_i       (take_redirect),
    .load_br_i    (br_taken),
    .load_val_i   (load_val),
    .stall_i      (stall),
    .active_o     (flush_active),
    .flush_ifid_o (flush_ifid),
    .flush_idex_o (flush_idex)
  );

  assign pc_out       = pc_q;
  assign pc_plus4     = pc_q + PcW'(InstrBytes);
  assign redirect     = redirect_q;
  assign misalign     = misalign_q;
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_pc_redirect.sv
// Bench for fetch_pc_redirect: directed scenarios with literal expectations plus random traffic.
// Every cycle is compared against a slot-counting behavioural model.
module tb_fetch_pc_redirect;

  localparam int BR = 2;
  localparam int JMP = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        jmp_valid = 1'b0;
  logic [31:0] jmp_target = '0;

  logic [31:0] pc_out, pc_plus4;
  logic        flush_ifid, flush_idex, redirect, misalign;
  logic [15:0] redirect_cnt;

  logic [31:0] s_pc_out, s_pc_plus4;
  logic        s_flush_ifid, s_flush_idex, s_redirect, s_misalign;
  logic [1:0]  s_redirect_cnt;

  fetch_pc_redirect dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .jmp_valid    (jmp_valid),
    .jmp_target   (jmp_target),
    .pc_out       (pc_out),
    .pc_plus4     (pc_plus4),
    .flush_ifid   (flush_ifid),
    .flush_idex   (flush_idex),
    .redirect     (redirect),
    .misalign     (misalign),
    .redirect_cnt (redirect_cnt)
  );

  fetch_pc_redirect #(
    .CNT_W (2)
  ) dut_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .jmp_valid    (jmp_valid),
    .jmp_target   (jmp_target),
    .pc_out       (s_pc_out),
    .pc_plus4     (s_pc_plus4),
    .flush_ifid   (s_flush_ifid),
    .flush_idex   (s_flush_idex),
    .redirect     (s_redirect),
    .misalign     (s_misalign),
    .redirect_cnt (s_redirect_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Model: PC, remaining squash slots, slots already consumed, and the redirect tally.
  logic [31:0] m_pc = '0;
  int          m_left = 0;
  int          m_done = 0;
  int          m_n = 0;
  bit          m_from_br = 1'b0;
  bit          m_mis = 1'b0;
  bit          m_red = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    if (!rst_n) begin
      m_pc = 32'h0; m_left = 0; m_done = 0; m_n = 0;
      m_from_br = 1'b0; m_mis = 1'b0; m_red = 1'b0;
    end else begin
      m_red = 1'b0;
      if (m_left == 0 && (br_taken || jmp_valid)) begin
        tgt       = br_taken ? br_target : jmp_target;
        m_pc      = tgt & 32'hFFFF_FFFC;
        m_red     = 1'b1;
        m_n       = m_n + 1;
        m_mis     = m_mis || (tgt % 4 != 0);
        m_left    = br_taken ? BR : JMP;
        m_from_br = br_taken;
        m_done    = 0;
      end else if (!stall) begin
        m_pc = m_pc + 32'd4;
        if (m_left > 0) begin
          m_left--;
          m_done++;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("pc_out", pc_out, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("redirect", 32'(redirect), 32'(m_red));
      chk("flush_ifid", 32'(flush_ifid), 32'(m_left > 0));
      chk("flush_idex", 32'(flush_idex), 32'(m_from_br && m_left > 0 && m_done == 0));
      chk("misalign", 32'(misalign), 32'(m_mis));
      chk("redirect_cnt", 32'(redirect_cnt), (m_n > 65535) ? 32'd65535 : 32'(m_n));
      chk("sat_pc_out", s_pc_out, m_pc);
      chk("sat_pc_plus4", s_pc_plus4, m_pc + 32'd4);
      chk("sat_redirect", 32'(s_redirect), 32'(m_red));
      chk("sat_flush_ifid", 32'(s_flush_ifid), 32'(m_left > 0));
      chk("sat_flush_idex", 32'(s_flush_idex), 32'(m_from_br && m_left > 0 && m_done == 0));
      chk("sat_misalign", 32'(s_misalign), 32'(m_mis));
      chk("sat_redirect_cnt", 32'(s_redirect_cnt), (m_n > 3) ? 32'd3 : 32'(m_n));
    end
  end

  task automatic step(input bit st, input bit br, input logic [31:0] bt,
                      input bit jv, input logic [31:0] jt);
    stall = st; br_taken = br; br_target = bt; jmp_valid = jv; jmp_target = jt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    // Reset held for two edges.
    rst_n = 1'b0;
    idle();
    chk_en = 1'b1;
    idle();
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_ifid", 32'(flush_ifid), 32'h0);
    chk("rst_idex", 32'(flush_idex), 32'h0);
    chk("rst_cnt", 32'(redirect_cnt), 32'h0);
    chk("rst_mis", 32'(misalign), 32'h0);
    rst_n = 1'b1;
    idle(); chk("run_pc4", pc_out, 32'h4);
    idle(); chk("run_pc8", pc_out, 32'h8);
    idle(); chk("run_pcC", pc_out, 32'hC);
    idle(); chk("run_pc10", pc_out, 32'h10);

    // Taken branch: two IF/ID squash slots, one ID/EX slot.
    step(1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
    chk("br_pc", pc_out, 32'h40);
    chk("br_redirect", 32'(redirect), 32'h1);
    chk("br_ifid0", 32'(flush_ifid), 32'h1);
    chk("br_idex0", 32'(flush_idex), 32'h1);
    idle();
    chk("br_pc44", pc_out, 32'h44);
    chk("br_ifid1", 32'(flush_ifid), 32'h1);
    chk("br_idex1", 32'(flush_idex), 32'h0);
    chk("br_redirect1", 32'(redirect), 32'h0);
    idle();
    chk("br_pc48", pc_out, 32'h48);
    chk("br_ifid2", 32'(flush_ifid), 32'h0);
    chk("br_cnt", 32'(redirect_cnt), 32'h1);

    // A jump arriving inside the flush window is a wrong-path source.
    step(1'b0, 1'b1, 32'h80, 1'b0, 32'h0); chk("sq_pc80", pc_out, 32'h80);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h200); chk("sq_pc84", pc_out, 32'h84);
    idle(); chk("sq_pc88", pc_out, 32'h88);
    chk("sq_cnt", 32'(redirect_cnt), 32'h2);

    // Stall holds the PC; a branch overrides the stall; stall freezes an active flush.
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h1C); chk("st_pc1C", pc_out, 32'h1C);
    idle(); chk("st_pc20", pc_out, 32'h20);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("st_hold", pc_out, 32'h20);
    end
    step(1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
    chk("st_br_pc", pc_out, 32'h100);
    chk("st_br_idex", 32'(flush_idex), 32'h1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("st_frz_pc", pc_out, 32'h100);
    chk("st_frz_ifid", 32'(flush_ifid), 32'h1);
    chk("st_frz_idex", 32'(flush_idex), 32'h1);
    idle();
    chk("st_pc104", pc_out, 32'h104);
    chk("st_idex_off", 32'(flush_idex), 32'h0);
    idle();
    chk("st_pc108", pc_out, 32'h108);
    chk("st_ifid_off", 32'(flush_ifid), 32'h0);
    chk("sat_cnt3", 32'(s_redirect_cnt), 32'h3);

    // Misaligned target is aligned, and the flag stays sticky. Then the PC wraps.
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h33);
    chk("mis_pc", pc_out, 32'h30);
    chk("mis_flag", 32'(misalign), 32'h1);
    idle();
    step(1'b0, 1'b1, 32'h50, 1'b0, 32'h0);
    chk("mis_sticky", 32'(misalign), 32'h1);
    idle(); idle();
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8); chk("wrap_f8", pc_out, 32'hFFFF_FFF8);
    idle(); chk("wrap_fc", pc_out, 32'hFFFF_FFFC);
    idle(); chk("wrap_0", pc_out, 32'h0);
    chk("cnt7", 32'(redirect_cnt), 32'h7);
    chk("sat_hold", 32'(s_redirect_cnt), 32'h3);

    // Reset in the middle of a flush clears everything on the next edge.
    step(1'b0, 1'b1, 32'h200, 1'b0, 32'h0);
    rst_n = 1'b0;
    idle();
    chk("mrst_ifid", 32'(flush_ifid), 32'h0);
    chk("mrst_idex", 32'(flush_idex), 32'h0);
    chk("mrst_pc", pc_out, 32'h0);
    chk("mrst_mis", 32'(misalign), 32'h0);
    rst_n = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      step(($urandom % 4) == 0, ($urandom % 8) == 0, $urandom,
           ($urandom % 6) == 0, $urandom);
    end

    chk_en = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
